param_serial_encoder: RTL and testbench
=======================================

// Module: param_serial_encoder
// PURPOSE
//  Inverse of the one-hot select decoder: accepts a DEPTH-bit request vector and
//  emits the binary index of every set bit, lowest first, one per output handshake.
//  Sits between a bitmask producer (status/interrupt vector) and a consumer that
//  needs indices, e.g. the select input of a parameterised decoder.
// PARAMETERS
//  DEPTH  8  width of the request vector; legal DEPTH >= 2; IDX_W = $clog2(DEPTH)
// PORTS
//  i_clk        in   1              clock; all logic on rising edge
//  i_rst_n      in   1              synchronous, active-low reset
//  i_enable     in   1              block enable; low freezes state, masks handshakes
//  i_req_vec    in   DEPTH          request bitmask
//  i_req_valid  in   1              request vector valid
//  o_req_ready  out  1              block can accept a vector
//  o_enc_out    out  IDX_W          index of the lowest pending bit
//  o_enc_valid  out  1              o_enc_out valid
//  i_enc_ready  in   1              consumer accepts o_enc_out
//  o_enc_last   out  1              current index is the final one of this vector
//  o_zero       out  1              one-cycle pulse: an all-zero vector was accepted
//  o_count      out  $clog2(DEPTH+1)  popcount of the vector being emitted
// BEHAVIOUR
//  - One clock, i_clk; reset is synchronous and active-low (i_rst_n). While
//    i_rst_n=0 at a clock edge: state=IDLE, pending=0, o_count=0, o_zero=0.
//    Hence o_req_ready=0 during reset, o_enc_valid=0, o_enc_out=0, o_enc_last=0.
//  - FSM states IDLE and EMIT.
//  - IDLE:
//    - o_req_ready = i_enable & i_rst_n; o_enc_valid = 0.
//    - Accept when i_req_valid & o_req_ready.
//    - Accepting a nonzero vector: pending <= i_req_vec, o_count <= popcount,
//      go to EMIT. The first index is valid the next cycle (latency 1).
//    - Accepting an all-zero vector: o_zero=1 for exactly one cycle, stay IDLE,
//      o_count <= 0.
//  - EMIT:
//    - o_req_ready = 0.
//    - o_enc_valid = i_enable. o_enc_out = index of the lowest set bit of pending.
//    - o_enc_last = 1 when pending has exactly one bit set.
//    - On handshake (o_enc_valid & i_enc_ready): clear that bit. If o_enc_last,
//      go to IDLE.
//    - No new vector is accepted in the same cycle as the last handshake; the
//      earliest next accept is the following cycle.
//  - Backpressure: while o_enc_valid & !i_enc_ready, o_enc_out, o_enc_last and
//    pending hold stable.
//  - i_enable=0 in any state:
//    - No accept and no handshake; o_enc_valid=0, o_req_ready=0.
//    - pending, state and o_count retained; resume unchanged when i_enable=1.
//  - Reset mid-EMIT: pending is discarded and no further indices are emitted.
//  - o_enc_out is 0 whenever o_enc_valid=0 (no X, no stale index).
//  - Index arithmetic is unsigned IDX_W. Bit DEPTH-1 yields DEPTH-1; there is
//    no wrap and no index >= DEPTH.
//  - i_req_vec is sampled only on accept; later changes are ignored.
// STRUCTURE
//  - Shared package enc_pkg:
//    - typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_e
//    - function automatic popcount
//  - Sub-module param_lsb_finder #(DEPTH): combinational; returns the lowest set
//    index and a one-hot of that bit (for clearing) from pending.
//  - Top level: FSM, pending register, o_count register, o_zero pulse register.
// TESTING  (DEPTH=8 unless stated)
//  1. Reset mid-EMIT after vec 8'hFF has emitted 0..2: hold i_rst_n=0 one cycle
//     -> all outputs at reset values; no index 3.
//  2. vec 8'b1010_0101, i_enc_ready=1 -> indices 0,2,5,7 on 4 consecutive cycles;
//     o_enc_last only with 7; o_count=4; o_req_ready high the cycle after.
//  3. vec 8'h80 -> single index 7 with o_enc_last=1; vec 8'h01 -> index 0, last=1.
//  4. vec 8'h00 -> o_zero pulse 1 cycle, o_enc_valid never high, o_count=0.
//  5. vec 8'h0C, i_enc_ready low 3 cycles -> o_enc_out=2 held stable; then 2,3.
//     Also drop i_enable mid-vector -> valid=0, resumes at same index.
//  6. Random vectors, DEPTH in {2,5,8,16}, random ready/enable. Scoreboard: OR of
//     (1<<index) over each vector equals the vector; indices strictly ascending.

Source files
------------

// File: rtl/param_serial_encoder_pkg.sv
// Shared types and helpers for the serial index encoder.
// Contents: FSM state enum, widest supported request vector, population count.
// Pure declarations; no logic, no latency, no flow control of its own.
package enc_pkg;

  // Widest request vector the popcount helper handles.
  localparam int MAX_DEPTH = 64;

  typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_e;

  // Number of set bits in a request vector, zero-extended to MAX_DEPTH.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/param_serial_encoder_if.sv
// Request-vector in / index-stream out bundle of the serial encoder.
// Ports: i_req_vec/i_req_valid/o_req_ready (vector in), o_enc_out/o_enc_valid/
//        i_enc_ready/o_enc_last (index out), o_zero pulse, o_count popcount.
// slave = encoder side, master = producer/consumer side.
interface param_serial_encoder_if #(
  parameter int DEPTH = 8
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] i_req_vec;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [IDX_W-1:0] o_enc_out;
  logic             o_enc_valid;
  logic             i_enc_ready;
  logic             o_enc_last;
  logic             o_zero;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_req_vec, i_req_valid, i_enc_ready,
    output o_req_ready, o_enc_out, o_enc_valid, o_enc_last, o_zero, o_count
  );

  modport master (
    output i_req_vec, i_req_valid, i_enc_ready,
    input  o_req_ready, o_enc_out, o_enc_valid, o_enc_last, o_zero, o_count
  );
endinterface

// File: rtl/param_serial_encoder_lsb_finder.sv
// Lowest-set-bit finder: binary index and one-hot mask of the lowest set bit.
// Ports: i_vec (DEPTH) in; o_idx (IDX_W), o_onehot (DEPTH) out.
// Purely combinational, zero latency; all-zero input gives index 0, mask 0.
module param_lsb_finder #(
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic [DEPTH-1:0] o_onehot
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + DEPTH'(1));

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/param_serial_encoder.sv
// Bitmask-to-index serializer: emits the index of each set bit, lowest first.
// Latency: first index valid the cycle after the vector is accepted; one index per handshake.
// Backpressure: index, last flag and pending mask hold while i_enc_ready is low;
//   new vectors are refused until the previous vector's last index is taken.
// Ports: i_clk, i_rst_n (sync, active-low), i_enable (freezes state, masks handshakes),
//   bus (slave modport of param_serial_encoder_if).
module param_serial_encoder
  import enc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  param_serial_encoder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  enc_state_e           state_q, state_d;
  logic [DEPTH-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 zero_q, zero_d;

  logic [IDX_W-1:0]     lsb_idx;
  logic [DEPTH-1:0]     lsb_onehot;
  logic [MAX_DEPTH-1:0] req_ext;
  logic                 req_ready;
  logic                 enc_valid;
  logic                 enc_last;
  logic                 accept;
  logic                 handshake;

  param_lsb_finder #(.DEPTH(DEPTH)) u_lsb_finder (
    .i_vec    (pending_q),
    .o_idx    (lsb_idx),
    .o_onehot (lsb_onehot)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;

    req_ext              = '0;
    req_ext[DEPTH-1:0]   = bus.i_req_vec;

    // Reset is folded in so nothing handshakes during the reset cycle itself.
    req_ready = (state_q == ENC_IDLE) & i_enable & i_rst_n;
    enc_valid = (state_q == ENC_EMIT) & i_enable & i_rst_n;
    // Exactly one bit left: the lowest set bit is the whole mask.
    enc_last  = enc_valid & (|pending_q) & (pending_q == lsb_onehot);

    accept    = bus.i_req_valid & req_ready;
    handshake = enc_valid & bus.i_enc_ready;

    if (accept) begin
      count_d = CNT_W'(popcount(req_ext));
      if (|bus.i_req_vec) begin
        pending_d = bus.i_req_vec;
        state_d   = ENC_EMIT;
      end else begin
        zero_d = 1'b1;
      end
    end

    if (handshake) begin
      pending_d = pending_q & ~lsb_onehot;
      if (enc_last) state_d = ENC_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ENC_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_enc_valid = enc_valid;
  assign bus.o_enc_out   = enc_valid ? lsb_idx : '0;
  assign bus.o_enc_last  = enc_last;
  assign bus.o_zero      = zero_q;
  assign bus.o_count     = count_q;

endmodule

// File: tb/tb_param_serial_encoder.sv
// Directed and randomized checks of param_serial_encoder.
// Main instance DEPTH=8 for directed vectors; DEPTH 2,5,8,16 instances for random traffic.
// Inputs driven and outputs sampled around the falling clock edge.
module tb_param_serial_encoder;

  logic clk;
  logic rst_n;
  logic en;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_serial_encoder_if #(.DEPTH(8)) m_if();

  param_serial_encoder #(.DEPTH(8)) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (en),
    .bus      (m_if.slave)
  );

  // Random-traffic instances, flattened to 16-bit arrays for indexed access.
  logic [15:0] r_vec   [4];
  logic        r_valid [4];
  logic        r_ready [4];
  logic        r_en    [4];
  logic [15:0] r_out   [4];
  logic        r_ov    [4];
  logic        r_rr    [4];
  logic        r_last  [4];
  logic        r_zero  [4];
  logic [4:0]  r_cnt   [4];

  for (genvar g = 0; g < 4; g++) begin : g_r
    localparam int D = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 8 : 16;
    param_serial_encoder_if #(.DEPTH(D)) rif();
    param_serial_encoder #(.DEPTH(D)) u_rdut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_enable (r_en[g]),
      .bus      (rif.slave)
    );
    assign rif.i_req_vec   = r_vec[g][D-1:0];
    assign rif.i_req_valid = r_valid[g];
    assign rif.i_enc_ready = r_ready[g];
    assign r_out[g]  = 16'(rif.o_enc_out);
    assign r_ov[g]   = rif.o_enc_valid;
    assign r_rr[g]   = rif.o_req_ready;
    assign r_last[g] = rif.o_enc_last;
    assign r_zero[g] = rif.o_zero;
    assign r_cnt[g]  = 5'(rif.o_count);
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 5 : (k == 2) ? 8 : 16;
  endfunction

  function automatic int pop16(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    m_if.i_req_vec = '0; m_if.i_req_valid = 1'b0; m_if.i_enc_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_if.o_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0h exp 0", m_if.o_req_ready); end
    checks++; if (m_if.o_enc_valid !== 1'b0) begin errors++; $display("FAIL rst_enc_valid got %0h exp 0", m_if.o_enc_valid); end
    checks++; if (m_if.o_enc_out !== 3'd0) begin errors++; $display("FAIL rst_enc_out got %0h exp 0", m_if.o_enc_out); end
    checks++; if (m_if.o_enc_last !== 1'b0) begin errors++; $display("FAIL rst_enc_last got %0h exp 0", m_if.o_enc_last); end
    checks++; if (m_if.o_zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %0h exp 0", m_if.o_zero); end
    checks++; if (m_if.o_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0h exp 0", m_if.o_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (m_if.o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h exp 1", m_if.o_req_ready); end

    // Start 0xFF, take indices 0..2, then reset with 3..7 still pending.
    @(negedge clk); m_if.i_req_vec = 8'hFF; m_if.i_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); m_if.i_req_valid = 1'b0; #1;
      checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'(k)) begin errors++; $display("FAIL midemit_idx%0d got v=%0h i=%0d exp v=1 i=%0d", k, m_if.o_enc_valid, m_if.o_enc_out, k); end
    end
    checks++; if (m_if.o_count !== 4'd8) begin errors++; $display("FAIL midemit_count got %0d exp 8", m_if.o_count); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (m_if.o_enc_valid !== 1'b0) begin errors++; $display("FAIL rstlow_valid got %0h exp 0", m_if.o_enc_valid); end
    @(negedge clk); #1;
    checks++; if (m_if.o_count !== 4'd0 || m_if.o_enc_out !== 3'd0 || m_if.o_enc_last !== 1'b0 || m_if.o_req_ready !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs got cnt=%0d out=%0d last=%0h rdy=%0h exp 0,0,0,0", m_if.o_count, m_if.o_enc_out, m_if.o_enc_last, m_if.o_req_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (m_if.o_enc_valid !== 1'b0 || m_if.o_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got v=%0h rdy=%0h exp v=0 rdy=1", m_if.o_enc_valid, m_if.o_req_ready); end
    @(negedge clk); #1;
    checks++; if (m_if.o_enc_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_idx3 got v=%0h out=%0d exp v=0", m_if.o_enc_valid, m_if.o_enc_out); end
  endtask

  task automatic test_pattern();
    int exp_idx [4];
    exp_idx = '{0, 2, 5, 7};
    @(negedge clk); m_if.i_req_vec = 8'hA5; m_if.i_req_valid = 1'b1; m_if.i_enc_ready = 1'b1; #1;
    checks++; if (m_if.o_req_ready !== 1'b1) begin errors++; $display("FAIL pat_accept_ready got %0h exp 1", m_if.o_req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      // Vector changes after accept must not matter; on the last index offer a new one.
      m_if.i_req_vec = (k == 3) ? 8'h01 : 8'hFF;
      m_if.i_req_valid = (k == 3);
      #1;
      checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'(exp_idx[k])) begin errors++; $display("FAIL pat_idx%0d got v=%0h i=%0d exp v=1 i=%0d", k, m_if.o_enc_valid, m_if.o_enc_out, exp_idx[k]); end
      checks++; if (m_if.o_enc_last !== (k == 3)) begin errors++; $display("FAIL pat_last%0d got %0h exp %0h", k, m_if.o_enc_last, (k == 3)); end
      checks++; if (m_if.o_count !== 4'd4 || m_if.o_req_ready !== 1'b0) begin errors++; $display("FAIL pat_cnt_rdy%0d got cnt=%0d rdy=%0h exp cnt=4 rdy=0", k, m_if.o_count, m_if.o_req_ready); end
    end
    @(negedge clk); m_if.i_req_valid = 1'b0; #1;
    checks++; if (m_if.o_req_ready !== 1'b1 || m_if.o_enc_valid !== 1'b0) begin errors++; $display("FAIL pat_after got rdy=%0h v=%0h exp rdy=1 v=0", m_if.o_req_ready, m_if.o_enc_valid); end
  endtask

  task automatic test_single();
    logic [7:0] vecs [2];
    int         idxs [2];
    vecs = '{8'h80, 8'h01};
    idxs = '{7, 0};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); m_if.i_req_vec = vecs[t]; m_if.i_req_valid = 1'b1; m_if.i_enc_ready = 1'b1; #1;
      checks++; if (m_if.o_req_ready !== 1'b1) begin errors++; $display("FAIL single%0d_ready got %0h exp 1", t, m_if.o_req_ready); end
      @(negedge clk); m_if.i_req_valid = 1'b0; #1;
      checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'(idxs[t]) || m_if.o_enc_last !== 1'b1 || m_if.o_count !== 4'd1)
        begin errors++; $display("FAIL single%0d got v=%0h i=%0d last=%0h cnt=%0d exp v=1 i=%0d last=1 cnt=1", t, m_if.o_enc_valid, m_if.o_enc_out, m_if.o_enc_last, m_if.o_count, idxs[t]); end
    end
  endtask

  task automatic test_zero();
    @(negedge clk); m_if.i_req_vec = 8'h00; m_if.i_req_valid = 1'b1; #1;
    checks++; if (m_if.o_req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %0h exp 1", m_if.o_req_ready); end
    @(negedge clk); m_if.i_req_valid = 1'b0; #1;
    checks++; if (m_if.o_zero !== 1'b1 || m_if.o_enc_valid !== 1'b0 || m_if.o_count !== 4'd0)
      begin errors++; $display("FAIL zero_pulse got z=%0h v=%0h cnt=%0d exp z=1 v=0 cnt=0", m_if.o_zero, m_if.o_enc_valid, m_if.o_count); end
    @(negedge clk); #1;
    checks++; if (m_if.o_zero !== 1'b0 || m_if.o_enc_valid !== 1'b0 || m_if.o_req_ready !== 1'b1)
      begin errors++; $display("FAIL zero_after got z=%0h v=%0h rdy=%0h exp z=0 v=0 rdy=1", m_if.o_zero, m_if.o_enc_valid, m_if.o_req_ready); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); m_if.i_req_vec = 8'h0C; m_if.i_req_valid = 1'b1; m_if.i_enc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); m_if.i_req_valid = 1'b0; #1;
      checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'd2 || m_if.o_enc_last !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got v=%0h i=%0d last=%0h exp v=1 i=2 last=0", k, m_if.o_enc_valid, m_if.o_enc_out, m_if.o_enc_last); end
    end
    @(negedge clk); en = 1'b0; m_if.i_enc_ready = 1'b1; #1;
    checks++; if (m_if.o_enc_valid !== 1'b0 || m_if.o_enc_out !== 3'd0 || m_if.o_req_ready !== 1'b0 || m_if.o_count !== 4'd2)
      begin errors++; $display("FAIL bp_disable got v=%0h i=%0d rdy=%0h cnt=%0d exp 0,0,0,2", m_if.o_enc_valid, m_if.o_enc_out, m_if.o_req_ready, m_if.o_count); end
    @(negedge clk); en = 1'b1; #1;
    checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'd2) begin errors++; $display("FAIL bp_resume got v=%0h i=%0d exp v=1 i=2", m_if.o_enc_valid, m_if.o_enc_out); end
    @(negedge clk); en = 1'b0; #1;
    checks++; if (m_if.o_enc_valid !== 1'b0 || m_if.o_enc_out !== 3'd0) begin errors++; $display("FAIL bp_disable2 got v=%0h i=%0d exp v=0 i=0", m_if.o_enc_valid, m_if.o_enc_out); end
    @(negedge clk); en = 1'b1; #1;
    checks++; if (m_if.o_enc_valid !== 1'b1 || m_if.o_enc_out !== 3'd3 || m_if.o_enc_last !== 1'b1)
      begin errors++; $display("FAIL bp_idx3 got v=%0h i=%0d last=%0h exp v=1 i=3 last=1", m_if.o_enc_valid, m_if.o_enc_out, m_if.o_enc_last); end
    @(negedge clk); #1;
    checks++; if (m_if.o_req_ready !== 1'b1 || m_if.o_count !== 4'd2) begin errors++; $display("FAIL bp_done got rdy=%0h cnt=%0d exp rdy=1 cnt=2", m_if.o_req_ready, m_if.o_count); end
  endtask

  task automatic test_random();
    logic        busy [4];
    logic        zero_pend [4];
    logic        acc_prev [4];
    logic [15:0] exp_vec [4];
    logic [15:0] seen [4];
    int          last_idx [4];
    int          nvec;
    int          idx;
    int          d;
    nvec = 0;
    for (int k = 0; k < 4; k++) begin
      busy[k] = 1'b0; zero_pend[k] = 1'b0; acc_prev[k] = 1'b0;
      exp_vec[k] = '0; seen[k] = '0; last_idx[k] = -1;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        d = depth_of(k);
        if (acc_prev[k]) r_valid[k] = 1'b0;
        if (!r_valid[k] && $urandom_range(0, 3) == 0) begin
          r_valid[k] = 1'b1;
          r_vec[k]   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom) & 16'((1 << d) - 1);
        end
        r_en[k]    = ($urandom_range(0, 9) != 0);
        r_ready[k] = ($urandom_range(0, 9) < 7);
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        d = depth_of(k);
        acc_prev[k] = 1'b0;
        checks++; if (r_zero[k] !== zero_pend[k]) begin errors++; $display("FAIL rnd_zero d%0d cyc%0d got %0h exp %0h", d, c, r_zero[k], zero_pend[k]); end
        zero_pend[k] = 1'b0;
        checks++; if (r_rr[k] !== (!busy[k] && r_en[k]) || r_ov[k] !== (busy[k] && r_en[k]))
          begin errors++; $display("FAIL rnd_state d%0d cyc%0d got rdy=%0h v=%0h exp rdy=%0h v=%0h", d, c, r_rr[k], r_ov[k], !busy[k] && r_en[k], busy[k] && r_en[k]); end
        if (!r_ov[k]) begin
          checks++; if (r_out[k] !== 16'h0) begin errors++; $display("FAIL rnd_out_idle d%0d got %0d exp 0", d, r_out[k]); end
        end
        if (r_valid[k] && r_rr[k]) begin
          acc_prev[k] = 1'b1;
          exp_vec[k]  = r_vec[k];
          seen[k]     = '0;
          last_idx[k] = -1;
          if (r_vec[k] == 16'h0) zero_pend[k] = 1'b1;
          else busy[k] = 1'b1;
        end else if (r_ov[k] && busy[k]) begin
          checks++; if (int'(r_cnt[k]) !== pop16(exp_vec[k])) begin errors++; $display("FAIL rnd_count d%0d got %0d exp %0d", d, r_cnt[k], pop16(exp_vec[k])); end
          if (r_ready[k]) begin
            idx = int'(r_out[k]);
            checks++; if (idx >= d || idx <= last_idx[k] || seen[k][idx % 16]) begin errors++; $display("FAIL rnd_index d%0d got %0d prev %0d exp ascending new index < %0d", d, idx, last_idx[k], d); end
            seen[k][idx % 16] = 1'b1;
            last_idx[k] = idx;
            if (r_last[k]) begin
              checks++; if (seen[k] !== exp_vec[k]) begin errors++; $display("FAIL rnd_vector d%0d got %0h exp %0h", d, seen[k], exp_vec[k]); end
              busy[k] = 1'b0;
              nvec++;
            end
          end
        end
      end
    end
    checks++; if (nvec < 100) begin errors++; $display("FAIL rnd_progress got %0d vectors exp >= 100", nvec); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b1;
    m_if.i_req_vec = '0; m_if.i_req_valid = 1'b0; m_if.i_enc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r_vec[k] = '0; r_valid[k] = 1'b0; r_ready[k] = 1'b0; r_en[k] = 1'b1;
    end
    test_reset();
    test_pattern();
    test_single();
    test_zero();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
